sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 35 +++
 rtl/sram_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller.
// Contents: FSM state encoding, transfer target encoding, Wishbone select
// bit indices, default SRAM address width, counter width and the select
// decode helper.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        TgtBase,
        TgtExt,
        TgtNone
    } target_e;

    localparam int unsigned SEL_BASE       = 0;
    localparam int unsigned SEL_EXT        = 1;
    localparam int unsigned ADDR_W_DEFAULT = 20;
    // Wide enough for WAIT_CYCLES-1 up to 14.
    localparam int unsigned CNT_W          = 4;

    // Base RAM wins over ext RAM; any other nonzero select is unmapped.
    function automatic target_e decode_target(input logic [15:0] sel);
        if (sel[SEL_BASE]) begin
            return TgtBase;
        end else if (sel[SEL_EXT]) begin
            return TgtExt;
        end
        return TgtNone;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Wishbone-to-asynchronous-SRAM controller for a base RAM and an ext RAM
// sharing one address/data bus.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wb_data_i/addr_i    write data and byte address from the bus master
//   wb_we_i             1 = write, 0 = read
//   wb_select_i         one-hot device select (bit0 base, bit1 ext)
//   wb_data_o/ack_o     read data and one-cycle completion pulse
//   sram_addr           word address (byte address / 4)
//   sram_data_o/oe      write data and data-bus drive enable
//   sram_data_i         read data from the SRAM
//   base_ce_n/ext_ce_n  chip enables, active-low
//   sram_oe_n/we_n      output / write enables, active-low
// A request is taken in IDLE, held for WAIT_CYCLES access cycles, then
// acknowledged in DONE. All outputs are registered.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wb_data_i,
    input  logic [31:0]       wb_addr_i,
    input  logic              wb_we_i,
    input  logic [15:0]       wb_select_i,
    output logic [31:0]       wb_data_o,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe,
    input  logic [31:0]       sram_data_i,
    output logic              base_ce_n,
    output logic              ext_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             xfer_we;
    target_e          req_tgt;
    logic             unused_addr;

    assign req_tgt     = decode_target(wb_select_i);
    // Byte-lane and above-range address bits are not part of the word address.
    assign unused_addr = ^{wb_addr_i[31:ADDR_W+2], wb_addr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StIdle;
            cnt          <= '0;
            xfer_we      <= 1'b0;
            wb_ack_o     <= 1'b0;
            wb_data_o    <= '0;
            base_ce_n    <= 1'b1;
            ext_ce_n     <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_data_oe <= 1'b0;
            sram_addr    <= '0;
            sram_data_o  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (wb_select_i != '0) begin
                        xfer_we     <= wb_we_i;
                        sram_addr   <= wb_addr_i[ADDR_W+1:2];
                        sram_data_o <= wb_data_i;
                        if (req_tgt == TgtNone) begin
                            // Unmapped: acknowledge straight away, no SRAM cycle.
                            state     <= StDone;
                            wb_ack_o  <= 1'b1;
                            wb_data_o <= '0;
                        end else begin
                            state        <= StAccess;
                            cnt          <= CNT_LOAD;
                            base_ce_n    <= (req_tgt != TgtBase);
                            ext_ce_n     <= (req_tgt != TgtExt);
                            sram_oe_n    <= wb_we_i;
                            // CNT_LOAD is never 0, so the first write cycle strobes.
                            sram_we_n    <= ~wb_we_i;
                            sram_data_oe <= wb_we_i;
                            if (wb_we_i) begin
                                wb_data_o <= '0;
                            end
                        end
                    end
                end
                StAccess: begin
                    if (cnt == '0) begin
                        state        <= StDone;
                        wb_ack_o     <= 1'b1;
                        base_ce_n    <= 1'b1;
                        ext_ce_n     <= 1'b1;
                        sram_oe_n    <= 1'b1;
                        sram_we_n    <= 1'b1;
                        sram_data_oe <= 1'b0;
                        if (!xfer_we) begin
                            wb_data_o <= sram_data_i;
                        end
                    end else begin
                        cnt       <= cnt - 1'b1;
                        // Release we_n for the final (hold) cycle, where cnt becomes 0.
                        sram_we_n <= ~(xfer_we && (cnt != CNT_W'(1)));
                    end
                end
                StDone: begin
                    wb_ack_o <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
